// File: rtl/controle_buzzer_pkg.sv
// Shared definitions for the buzzer sequencer: note codes, the error melody
// and the FSM state type.
package buzzer_pkg;

    typedef logic [3:0] nota_t;

    localparam nota_t NOTA_DO       = 4'b1000;
    localparam nota_t NOTA_RE       = 4'b0010;
    localparam nota_t NOTA_SOL      = 4'b0001;
    localparam nota_t NOTA_LA       = 4'b0100;
    localparam nota_t NOTA_SILENCIO = 4'b0000;

    localparam nota_t MELODIA_ERRO [0:3] = '{NOTA_LA, NOTA_SOL, NOTA_RE, NOTA_DO};

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        PREPARA = 3'd1,
        TOCA    = 3'd2,
        PAUSA   = 3'd3,
        FINAL   = 3'd4
    } estado_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/controle_buzzer_if.sv
// Request/response bundle between the game control unit (master) and the
// buzzer sequencer (slave).
interface controle_buzzer_if;
    import buzzer_pkg::*;

    logic  iniciar;
    logic  melodia;
    nota_t nota;
    logic  parar;
    nota_t seletor;
    logic  conta;
    logic  zera_buzzer;
    logic  ocupado;
    logic  fim;

    modport master (
        output iniciar, melodia, nota, parar,
        input  seletor, conta, zera_buzzer, ocupado, fim
    );

    modport slave (
        input  iniciar, melodia, nota, parar,
        output seletor, conta, zera_buzzer, ocupado, fim
    );
endinterface

// File: rtl/controle_buzzer_temporizador.sv
// Loadable down-counter that stops at zero; used to time notes and gaps.
module temporizador #(
    parameter int unsigned LARGURA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               carrega,
    input  logic [LARGURA-1:0] valor,
    output logic               zero
);

    logic [LARGURA-1:0] r_cont;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cont <= '0;
        end else if (carrega) begin
            r_cont <= valor;
        end else if (r_cont != '0) begin
            r_cont <= r_cont - LARGURA'(1);
        end
    end

    assign zero = (r_cont == '0);

endmodule

// File: rtl/controle_buzzer.sv
// Buzzer sequencer: plays one note or the four-note error melody, each note
// followed by an optional silent gap, then pulses fim.
module controle_buzzer
    import buzzer_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned DURACAO_MS = 500,
    parameter int unsigned PAUSA_MS   = 100
) (
    input logic               clock,
    input logic               reset,
    controle_buzzer_if.slave  barramento
);

    // 64-bit products: the default clock times the note length overflows 32 bits
    localparam longint unsigned DUR_L = (64'(CLOCK_FREQ) * 64'(DURACAO_MS)) / 64'd1000;
    localparam longint unsigned PAU_L = (64'(CLOCK_FREQ) * 64'(PAUSA_MS)) / 64'd1000;
    localparam int unsigned DUR_CICLOS = 32'(DUR_L);
    localparam int unsigned PAU_CICLOS = 32'(PAU_L);

    localparam int unsigned LARG_CALC = $clog2(max_u(DUR_CICLOS, PAU_CICLOS) + 1);
    localparam int unsigned LARG      = (LARG_CALC < 1) ? 1 : LARG_CALC;
    localparam bit          TEM_PAUSA = (PAU_CICLOS > 0);

    localparam logic [LARG-1:0] CARGA_TOCA  = LARG'(DUR_CICLOS - 1);
    localparam logic [LARG-1:0] CARGA_PAUSA = TEM_PAUSA ? LARG'(PAU_CICLOS - 1) : '0;

    if (DUR_CICLOS < 1) begin : g_duracao_invalida
        $error("controle_buzzer: note duration must be at least one clock cycle");
    end

    estado_t         r_estado;
    estado_t         w_prox;
    logic [1:0]      r_idx;
    logic            r_melodia;
    nota_t           r_nota;
    nota_t           r_seletor;
    logic            r_conta;
    logic            r_zera;
    logic            r_ocupado;
    logic            r_fim;
    logic            w_carrega;
    logic [LARG-1:0] w_valor;
    logic            w_zero;
    logic            w_avanca_idx;
    logic            w_mais_notas;
    estado_t         w_apos_nota;
    nota_t           w_nota_tocar;

    temporizador #(.LARGURA(LARG)) u_temporizador (
        .clock   (clock),
        .reset   (reset),
        .carrega (w_carrega),
        .valor   (w_valor),
        .zero    (w_zero)
    );

    assign w_mais_notas = r_melodia && (r_idx != 2'd3);
    assign w_apos_nota  = w_mais_notas ? PREPARA : FINAL;
    assign w_nota_tocar = r_melodia ? MELODIA_ERRO[r_idx] : r_nota;

    always_comb begin
        w_prox       = r_estado;
        w_carrega    = 1'b0;
        w_valor      = CARGA_TOCA;
        w_avanca_idx = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (barramento.iniciar) w_prox = PREPARA;
            end
            PREPARA: begin
                w_carrega = 1'b1;
                w_valor   = CARGA_TOCA;
                w_prox    = TOCA;
            end
            TOCA: begin
                if (w_zero) begin
                    if (TEM_PAUSA) begin
                        w_carrega = 1'b1;
                        w_valor   = CARGA_PAUSA;
                        w_prox    = PAUSA;
                    end else begin
                        w_prox       = w_apos_nota;
                        w_avanca_idx = w_mais_notas;
                    end
                end
            end
            PAUSA: begin
                if (w_zero) begin
                    w_prox       = w_apos_nota;
                    w_avanca_idx = w_mais_notas;
                end
            end
            FINAL:   w_prox = OCIOSO;
            default: w_prox = OCIOSO;
        endcase
        if (barramento.parar) begin
            w_prox       = OCIOSO;
            w_carrega    = 1'b0;
            w_avanca_idx = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with r_estado
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado  <= OCIOSO;
            r_idx     <= '0;
            r_melodia <= 1'b0;
            r_nota    <= NOTA_SILENCIO;
            r_seletor <= NOTA_SILENCIO;
            r_conta   <= 1'b0;
            r_zera    <= 1'b0;
            r_ocupado <= 1'b0;
            r_fim     <= 1'b0;
        end else begin
            r_estado <= w_prox;
            if (r_estado == OCIOSO && w_prox == PREPARA) begin
                r_melodia <= barramento.melodia;
                r_nota    <= $onehot(barramento.nota) ? barramento.nota : NOTA_SILENCIO;
                r_idx     <= '0;
            end else if (w_avanca_idx) begin
                r_idx <= r_idx + 2'd1;
            end
            r_seletor <= (w_prox == TOCA) ? w_nota_tocar : NOTA_SILENCIO;
            r_conta   <= (w_prox == TOCA);
            r_zera    <= (w_prox == PREPARA);
            r_ocupado <= (w_prox != OCIOSO);
            r_fim     <= (w_prox == FINAL);
        end
    end

    assign barramento.seletor     = r_seletor;
    assign barramento.conta       = r_conta;
    assign barramento.zera_buzzer = r_zera;
    assign barramento.ocupado     = r_ocupado;
    assign barramento.fim         = r_fim;

endmodule

// File: doc/controle_buzzer.md
# controle_buzzer

Sequencer that drives the buzzer tone generator: on request it plays one note, or a fixed four-note error melody, for a timed duration followed by a silent gap. It owns the buzzer's `seletor`, `conta` and `reset` inputs and signals completion to the game FSM. It sits between the main control unit and the buzzer instance.

## Interface

Parameters:
- `CLOCK_FREQ`, 50_000_000, clock frequency in Hz.
- `DURACAO_MS`, 500, note duration in ms.
  - `DUR_CICLOS = CLOCK_FREQ*DURACAO_MS/1000`.
  - Elaboration error if `DUR_CICLOS < 1`.
- `PAUSA_MS`, 100, silent gap after each note in ms.
  - `PAU_CICLOS = CLOCK_FREQ*PAUSA_MS/1000`.
  - 0 is allowed and means no gap.

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `iniciar` in 1: start request, sampled on the rising edge.
- `melodia` in 1: sampled with `iniciar`. 1 = play the error melody; 0 = play a single note.
- `nota` in 4: one-hot note code, sampled with `iniciar`. Ignored when `melodia=1`.
- `parar` in 1: synchronous abort.
- `seletor` out 4: note code sent to the buzzer.
- `conta` out 1: buzzer count enable.
- `zera_buzzer` out 1: synchronous clear for the buzzer counters.
- `ocupado` out 1: high in every state except OCIOSO.
- `fim` out 1: one-cycle completion pulse.

## Operation

Note codes (buzzer mux order):
- DO = 4'b1000
- RE = 4'b0010
- SOL = 4'b0001
- LA = 4'b0100
- Silence = 4'b0000
- The melody is LA, SOL, RE, DO, played at index 0..3.

State machine (Moore; all outputs are registered):
- **OCIOSO**
  - `seletor=0`, `conta=0`, `zera_buzzer=0`, `ocupado=0`, `fim=0`.
  - On `iniciar` (with `parar=0`): latch `melodia` and `nota`, set `idx=0`, go to PREPARA.
- **PREPARA**
  - Lasts 1 cycle. `zera_buzzer=1`, `seletor=0`, `conta=0`.
  - Loads the timer with `DUR_CICLOS-1`, then goes to TOCA.
- **TOCA**
  - `seletor` = latched note, or the melody entry at `idx`. `conta=1`.
  - Timer decrements each cycle. When the timer reads 0: go to PAUSA if `PAU_CICLOS>0`, otherwise go to the "next" decision.
- **PAUSA**
  - `seletor=0`, `conta=0`. Lasts `PAU_CICLOS` cycles, then the "next" decision.
- **Next decision**
  - If the melody is active and `idx<3`: increment `idx`, go to PREPARA.
  - Otherwise go to FINAL.
- **FINAL**
  - Lasts 1 cycle. `fim=1`, `ocupado=1`, `seletor=0`. Then goes to OCIOSO.

Boundary rules:
- `iniciar` while `ocupado=1` is ignored; nothing is queued.
- `iniciar` arriving in the FINAL cycle is also ignored.
- `parar` in any state: the next state is OCIOSO, with all outputs at idle values and no `fim` pulse.
- `parar` and `iniciar` in the same cycle: `parar` wins.
- A non-one-hot `nota` is accepted. It is played as `seletor=0000` (silence) with full timing and `fim` still pulses.
- `reset` mid-operation: next cycle is OCIOSO, timer=0, `idx=0`, all outputs 0. `reset` has priority over `parar` and `iniciar`.
- Timer width is `$clog2(max(DUR_CICLOS,PAU_CICLOS)+1)` bits. The timer never wraps: it is reloaded on every entry to TOCA or PAUSA.

## Timing

- Reset values: `seletor=0`, `conta=0`, `zera_buzzer=0`, `ocupado=0`, `fim=0`, state OCIOSO.
- `iniciar` sampled at edge 0:
  - PREPARA during cycle 1.
  - TOCA during cycles 2..`DUR_CICLOS+1`.
  - PAUSA during the next `PAU_CICLOS` cycles.
  - FINAL in the following cycle.
- Single note: `ocupado` is high for `DUR_CICLOS+PAU_CICLOS+2` cycles.
- Melody: `ocupado` is high for `4*(DUR_CICLOS+PAU_CICLOS+1)+1` cycles.
- `conta` is high for exactly `DUR_CICLOS` cycles per note. `zera_buzzer` precedes each note by one cycle.

## Structure

- Package `buzzer_pkg` contains:
  - Note code constants `NOTA_DO`, `NOTA_RE`, `NOTA_SOL`, `NOTA_LA`, `NOTA_SILENCIO`.
  - Melody constant array `MELODIA_ERRO[0:3]`.
  - State enum `estado_t` (OCIOSO, PREPARA, TOCA, PAUSA, FINAL).
- One sub-module `temporizador`: a loadable down-counter.
  - Inputs: `clock`, `reset`, `carrega`, `valor`.
  - Output: `zero`.
  - Width comes from a parameter.
- FSM and `idx` register live in `controle_buzzer`.

## Test plan

All scenarios use `CLOCK_FREQ=1000`, `DURACAO_MS=5`, `PAUSA_MS=2`, giving DUR=5 and PAU=2.

- **Single note:** `iniciar=1`, `melodia=0`, `nota=0100` for 1 cycle -> `zera_buzzer` high in cycle 1; `seletor=0100` with `conta=1` in cycles 2–6; silence in cycles 7–8; `fim` high in cycle 9; `ocupado` high in cycles 1–9.
- **Melody:** `iniciar`, `melodia=1` -> `seletor` shows 0100, 0001, 0010, 1000, each for 5 cycles, separated by 2 silent cycles plus 1 PREPARA cycle; single `fim` pulse at cycle 33.
- **Busy and same-cycle requests:**
  - Second `iniciar` (`nota=1000`) at cycle 4 of a note -> ignored; `seletor` stays 0100; `fim` pulses exactly once.
  - `iniciar` and `parar` together while idle -> stays OCIOSO.
- **Abort:** `parar` at cycle 3 of melody note 2 -> next cycle all outputs 0, no `fim`; a new `iniciar` afterwards plays a full note normally.
- **Reset mid-PAUSA:** assert `reset` -> next cycle state OCIOSO, outputs 0. After reset deasserts, `melodia=1` restarts from LA.
- **Invalid note:** `nota=0011` -> `seletor=0000` for 5 cycles, `conta=1`, `fim` at cycle 9.
- **PAUSA_MS=0 variant:** single note -> `fim` at cycle 7; melody notes are back-to-back with only the PREPARA cycle between them.
